// File: rtl/r4_seq_pkg.sv
// Shared types and helpers for the radix-4 butterfly sequencer.
package r4_seq_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Wide enough to hold the largest butterfly latency (3).
  localparam int CNT_W = 2;

  function automatic logic [2:0] k_to_sel(input logic [1:0] k);
    logic [2:0] sel;
    case (k)
      2'd0:    sel = 3'b000;
      2'd1:    sel = 3'b001;
      2'd2:    sel = 3'b010;
      default: sel = 3'b100;
    endcase
    return sel;
  endfunction

  function automatic logic [1:0] digit_rev(input logic [1:0] k);
    return {k[0], k[1]};
  endfunction

endpackage

// File: rtl/r4_seq_wait_cnt.sv
// Loadable down-counter; strobe is high while the count sits at zero,
// marking the cycle in which the butterfly result may be captured.
module r4_seq_wait_cnt
  import r4_seq_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic strobe
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state is updated with <= only, so every flop samples
  // the pre-edge value of its neighbours regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign strobe = (cnt_q == '0);

endmodule

// File: rtl/r4_butter_seq.sv
// Radix-4 butterfly sequencer: load 4 samples, step X0..X3 through the
// butterfly, stream the 4 results. Define R4_SEQ_BITREV_EN for 0,2,1,3 output order.
module r4_butter_seq
  import r4_seq_pkg::*;
#(
  parameter int W      = 4,
  parameter int BF_LAT = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_xr,
  input  logic [W-1:0]   in_xi,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_xr,
  output logic [W-1:0]   out_xi,
  output logic [1:0]     out_idx,
  output logic [4*W-1:0] bf_xr,
  output logic [4*W-1:0] bf_xi,
  output logic [2:0]     bf_c,
  input  logic [W-1:0]   bf_Xro,
  input  logic [W-1:0]   bf_Xio,
  output logic           busy,
  output logic           frame_done
);

  state_e       state_q, state_d;
  logic [1:0]   n_q, n_d;
  logic [1:0]   k_q, k_d;
  logic [1:0]   slot;
  logic [W-1:0] opr_q [4];
  logic [W-1:0] opr_d [4];
  logic [W-1:0] opi_q [4];
  logic [W-1:0] opi_d [4];
  logic [W-1:0] resr_q [4];
  logic [W-1:0] resr_d [4];
  logic [W-1:0] resi_q [4];
  logic [W-1:0] resi_d [4];
  logic         accept, xfer;
  logic         cnt_load, cnt_strobe;

  r4_seq_wait_cnt #(.LAT(BF_LAT)) u_wait_cnt (
    .clk    (CLK),
    .rst    (RST),
    .load   (cnt_load),
    .strobe (cnt_strobe)
  );

  // k_q doubles as the RUN capture index and the OUT transfer index.
  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    opr_d     = opr_q;
    opi_d     = opi_q;
    resr_d    = resr_q;
    resi_d    = resi_q;
    cnt_load  = 1'b0;
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == OUT);
    accept    = in_valid & in_ready;
    xfer      = out_valid & out_ready;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          opr_d[n_q] = in_xr;
          opi_d[n_q] = in_xi;
          n_d        = n_q + 2'd1;
          if (n_q == 2'd3) begin
            state_d  = RUN;
            cnt_load = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt_strobe) begin
          resr_d[k_q] = bf_Xro;
          resi_d[k_q] = bf_Xio;
          k_d         = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = OUT;
          end else begin
            cnt_load = 1'b1;
          end
        end
      end
      OUT: begin
        if (xfer) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
`ifdef R4_SEQ_BITREV_EN
    slot = digit_rev(k_q);
`else
    slot = k_q;
`endif
    bf_xr      = {opr_q[3], opr_q[2], opr_q[1], opr_q[0]};
    bf_xi      = {opi_q[3], opi_q[2], opi_q[1], opi_q[0]};
    bf_c       = (state_q == RUN) ? k_to_sel(k_q) : 3'b000;
    out_xr     = out_valid ? resr_q[slot] : '0;
    out_xi     = out_valid ? resi_q[slot] : '0;
    out_idx    = out_valid ? slot : 2'b00;
    busy       = !((state_q == LOAD) && (n_q == 2'd0));
    frame_done = xfer && (k_q == 2'd3);
  end

  // NOTE: the operand and result arrays are reset as well, because reset
  // must discard a partial frame and the operands drive bf_xr/bf_xi directly.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= LOAD;
      n_q     <= '0;
      k_q     <= '0;
      opr_q   <= '{default: '0};
      opi_q   <= '{default: '0};
      resr_q  <= '{default: '0};
      resi_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      opr_q   <= opr_d;
      opi_q   <= opi_d;
      resr_q  <= resr_d;
      resi_q  <= resi_d;
    end
  end

endmodule
